// File: rtl/ofdm_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_pkg
// Shared constants and types for the 802.16 receive-side data-symbol
// sequencer: FFT size, guard/DC/pilot positions (as FFT bin numbers 0..255,
// where bin k carries logical subcarrier k-128), the sequencer state enum and
// the per-carrier classification flags.
// ----------------------------------------------------------------------------
package ofdm_pkg;

   localparam int NFFT     = 256;   // subcarriers per OFDM symbol
   localparam int N_DATA   = 192;   // data carriers per OFDM symbol
   localparam int GUARD_LO = 28;    // bins 0..27 are lower guard
   localparam int GUARD_HI = 27;    // bins 229..255 are upper guard
   localparam int DC_POS   = 128;   // logical carrier 0
   localparam int N_PILOT  = 8;

   // Pilots at logical -88, -63, -38, -13, +13, +38, +63, +88.
   localparam logic [7:0] PILOT_POS [N_PILOT] = '{
      8'd40, 8'd65, 8'd90, 8'd115, 8'd141, 8'd166, 8'd191, 8'd216
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic guard;
      logic dc;
      logic pilot;
      logic data;
   } carrier_flags_t;

   function automatic logic is_pilot(input logic [7:0] pos);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_PILOT; i++) begin
         if (pos == PILOT_POS[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/data_sym_sched_if.sv
// ----------------------------------------------------------------------------
// data_sym_sched_if
// Wishbone-style streaming link carrying one complex subcarrier per beat.
//   dat [31:0]  subcarrier, [31:16] Im, [15:0] Re, signed Q1.15
//   we          write qualifier
//   stb         strobe (beat valid)
//   cyc         frame cycle
//   ack         beat accepted (driven by the slave)
// ----------------------------------------------------------------------------
interface data_sym_sched_if;

   logic [31:0] dat;
   logic        we;
   logic        stb;
   logic        cyc;
   logic        ack;

   modport master (output dat, output we, output stb, output cyc, input  ack);
   modport slave  (input  dat, input  we, input  stb, input  cyc, output ack);

endinterface

// File: rtl/data_sym_sched_carrier_class.sv
// ----------------------------------------------------------------------------
// carrier_class
// Combinational classifier of an FFT bin position into guard / DC / pilot /
// data. Exactly one flag is set for every position.
//   pos   [7:0]  FFT bin 0..255 (logical carrier pos-128)
//   flags        {guard, dc, pilot, data}
// ----------------------------------------------------------------------------
module carrier_class
   import ofdm_pkg::*;
(
   input  logic [7:0]     pos,
   output carrier_flags_t flags
);

   localparam logic [7:0] LO_END   = 8'(GUARD_LO);
   localparam logic [7:0] HI_START = 8'(NFFT - GUARD_HI);
   localparam logic [7:0] DC_BIN   = 8'(DC_POS);

   logic guard;
   logic dc;
   logic pilot;

   // NOTE: every signal written in an always_comb is given a value on every
   // path (here unconditionally) so no latch can be inferred.
   always_comb begin
      guard = (pos < LO_END) || (pos >= HI_START);
      dc    = (pos == DC_BIN);
      pilot = is_pilot(pos);

      flags       = '0;
      flags.guard = guard;
      flags.dc    = dc;
      flags.pilot = pilot;
      flags.data  = ~(guard | dc | pilot);
   end

endmodule

// File: rtl/data_sym_sched.sv
// ----------------------------------------------------------------------------
// data_sym_sched
// Per-frame sequencer in front of the QPSK data-symbol demapper. Takes 256
// equalised subcarriers per OFDM symbol from the upstream link, drops guard,
// DC and pilot bins and forwards the 192 data carriers downstream, framing
// NUM_SYM symbols in one downstream CYC burst.
//   CLK_I        system clock
//   RST_I        synchronous active-high reset
//   up           upstream link (slave side: DAT_I/WE_I/STB_I/CYC_I in, ACK_O out)
//   dn           downstream link (master side: DAT_O/WE_O/STB_O/CYC_O out, ACK_I in)
//   SYM_IDX_O    current symbol index within the frame
//   FRM_DONE_O   pulse when the frame's last data carrier is accepted downstream
//   ERR_O        pulse when the frame is aborted by CYC_I dropping mid-symbol
// ----------------------------------------------------------------------------
module data_sym_sched
   import ofdm_pkg::*;
#(
   parameter int NUM_SYM = 8
)(
   input  logic                    CLK_I,
   input  logic                    RST_I,
   data_sym_sched_if.slave         up,
   data_sym_sched_if.master        dn,
   output logic [7:0]              SYM_IDX_O,
   output logic                    FRM_DONE_O,
   output logic                    ERR_O
);

   localparam logic [7:0] SYM_LAST = 8'(NUM_SYM - 1);

   state_t         state;
   state_t         state_nxt;
   logic [7:0]     sc_cnt;
   logic [7:0]     sym_cnt;
   logic [31:0]    dat_q;
   logic           stb_q;
   logic           cyc_q;
   carrier_flags_t flags;

   logic out_halt;
   logic ena;
   logic ack_o;
   logic take;
   logic is_data;
   logic data_take;
   logic frame_end;
   logic abort;
   logic frm_done;
   logic err;

   carrier_class u_carrier_class (
      .pos   (sc_cnt),
      .flags (flags)
   );

   // Handshake terms. ACK_O stays low while a forwarded beat is stalled, so a
   // data take can never overwrite a DAT_O that has not been accepted yet.
   assign out_halt  = stb_q & ~dn.ack;
   assign ena       = up.cyc & up.stb & up.we;
   assign ack_o     = ena & ~out_halt & (state != FLUSH) & ~RST_I;
   assign take      = ena & ack_o;
   // The classifier flags are one-hot; masking with the drop flags keeps a
   // mis-mapped bin from ever reaching the demapper.
   assign is_data   = flags.data & ~(flags.guard | flags.dc | flags.pilot);
   assign data_take = take & is_data;
   assign frame_end = take & (sc_cnt == 8'hFF) & (sym_cnt == SYM_LAST);
   // CYC_I low exactly between symbols is a pause, not an abort.
   assign abort     = (state == RUN) & ~up.cyc & (sc_cnt != 8'd0);

   always_comb begin
      state_nxt = state;
      frm_done  = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (take) state_nxt = RUN;
         end
         RUN: begin
            if (abort) begin
               err       = 1'b1;
               state_nxt = IDLE;
            end else if (frame_end) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            // Done once no forwarded beat is left waiting downstream.
            if (~out_halt) begin
               frm_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state   <= IDLE;
         sc_cnt  <= '0;
         sym_cnt <= '0;
         dat_q   <= '0;
         stb_q   <= 1'b0;
         cyc_q   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (abort) begin
            sc_cnt  <= '0;
            sym_cnt <= '0;
         end else if (take) begin
            sc_cnt <= sc_cnt + 8'd1;
            if (sc_cnt == 8'hFF) begin
               sym_cnt <= (sym_cnt == SYM_LAST) ? 8'd0 : sym_cnt + 8'd1;
            end
         end

         if (data_take) begin
            dat_q <= up.dat;
            stb_q <= 1'b1;
         end else if (dn.ack) begin
            stb_q <= 1'b0;
         end

         // CYC_O rises with the first forwarded beat; after an abort it is
         // held until the pending beat has drained.
         if (data_take) begin
            cyc_q <= 1'b1;
         end else if (frm_done) begin
            cyc_q <= 1'b0;
         end else if ((state == IDLE) && !stb_q) begin
            cyc_q <= 1'b0;
         end
      end
   end

   assign up.ack     = ack_o;
   assign dn.dat     = dat_q;
   assign dn.stb     = stb_q;
   assign dn.we      = stb_q;
   assign dn.cyc     = cyc_q;
   assign SYM_IDX_O  = sym_cnt;
   assign FRM_DONE_O = frm_done & ~RST_I;
   assign ERR_O      = err & ~RST_I;

endmodule

// File: tb/tb_data_sym_sched.sv
// ----------------------------------------------------------------------------
// tb_data_sym_sched
// Self-checking bench for data_sym_sched (NUM_SYM = 2). Random subcarrier
// values are pushed through; a carrier-map model in logical-index terms builds
// the queue of data carriers that must appear downstream, in order.
// ----------------------------------------------------------------------------
module tb_data_sym_sched;

   localparam int NSYM      = 2;
   localparam int BEATS_FRM = NSYM * 192;
   localparam int TAKES_FRM = NSYM * 256;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sym_idx;
   logic       frm_done;
   logic       err;

   always #5 clk = ~clk;

   data_sym_sched_if up_if ();
   data_sym_sched_if dn_if ();

   data_sym_sched #(.NUM_SYM(NSYM)) dut (
      .CLK_I      (clk),
      .RST_I      (rst),
      .up         (up_if),
      .dn         (dn_if),
      .SYM_IDX_O  (sym_idx),
      .FRM_DONE_O (frm_done),
      .ERR_O      (err)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] exp_q [$];
   int          tb_k      = 0;
   int          tb_sym    = 0;
   int          exp_done  = 0;
   logic [31:0] last_in   = '0;
   logic [31:0] k28_val   = '0;
   logic [31:0] cur;
   int          ack_mode  = 0;   // 0: ACK_I low, 1: ACK_I high, 2: random

   function automatic bit is_data_k(input int k);
      int l;
      int pil [4];
      pil = '{13, 38, 63, 88};
      l = k - 128;
      if (l < -100 || l > 100 || l == 0) return 1'b0;
      foreach (pil[i]) if (l == pil[i] || l == -pil[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_take(input logic [31:0] d);
      if (is_data_k(tb_k)) begin
         exp_q.push_back(d);
         last_in = d;
      end
      if (tb_k == 28 && tb_sym == 0) k28_val = d;
      tb_k++;
      if (tb_k == 256) begin
         tb_k = 0;
         tb_sym++;
         if (tb_sym == NSYM) begin
            tb_sym = 0;
            exp_done++;
         end
      end
   endtask

   // ---------------- monitor ----------------
   int          beats     = 0;
   logic [31:0] first_dat = '0;
   int          n_done    = 0;
   int          n_err     = 0;
   bit          done_prev = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (dn_if.stb && dn_if.ack) begin
            if (beats == 0) first_dat = dn_if.dat;
            beats++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("beat_data", dn_if.dat, exp_q.pop_front());
         end
         if (frm_done) begin
            n_done++;
            check("cyc_at_done", 32'(dn_if.cyc), 32'd1);
         end
         if (done_prev) check("cyc_after_done", 32'(dn_if.cyc), 32'd0);
         done_prev = frm_done;
         if (err) n_err++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      case (ack_mode)
         0:       dn_if.ack = 1'b0;
         1:       dn_if.ack = 1'b1;
         default: dn_if.ack = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic push_samples(input int n, input bit gaps, output int cycles);
      int sent;
      sent   = 0;
      cycles = 0;
      while (sent < n && cycles < n * 8 + 200) begin
         tick();
         up_if.cyc = 1'b1;
         up_if.we  = 1'b1;
         up_if.stb = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         up_if.dat = cur;
         @(negedge clk);
         check("sym_idx", 32'(sym_idx), 32'(tb_sym));
         if (up_if.stb && up_if.ack) begin
            model_take(cur);
            sent++;
            cur = $urandom;
         end
         cycles++;
      end
      check("push_takes", 32'(sent), 32'(n));
   endtask

   task automatic wait_done(input int target);
      int c;
      c = 0;
      tick();
      up_if.stb = 1'b0;
      while (n_done < target && c < 300) begin
         tick();
         c++;
      end
      check("frm_done_cnt", 32'(n_done), 32'(target));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cyc_used;

      rst       = 1'b1;
      up_if.cyc = 1'b0;
      up_if.stb = 1'b0;
      up_if.we  = 1'b0;
      up_if.dat = '0;
      dn_if.ack = 1'b0;
      cur       = $urandom;

      // Reset values.
      repeat (3) tick();
      @(negedge clk);
      check("rst_stb",  32'(dn_if.stb), 32'd0);
      check("rst_cyc",  32'(dn_if.cyc), 32'd0);
      check("rst_we",   32'(dn_if.we),  32'd0);
      check("rst_dat",  dn_if.dat,      32'd0);
      check("rst_sym",  32'(sym_idx),   32'd0);
      check("rst_done", 32'(frm_done),  32'd0);
      check("rst_err",  32'(err),       32'd0);
      check("rst_ack",  32'(up_if.ack), 32'd0);
      tick();
      rst = 1'b0;

      // One full frame, ACK_I held high, continuous strobe.
      ack_mode = 1;
      beats    = 0;
      push_samples(TAKES_FRM, 1'b0, cyc_used);
      wait_done(1);
      check("t1_beats",    32'(beats), 32'(BEATS_FRM));
      check("t1_first",    first_dat,  k28_val);
      check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

      // Downstream stall mid-symbol.
      beats = 0;
      push_samples(60, 1'b0, cyc_used);
      ack_mode = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         up_if.stb = 1'b1;
         up_if.dat = cur;
         @(negedge clk);
         check("stall_ack", 32'(up_if.ack), 32'd0);
         check("stall_stb", 32'(dn_if.stb), 32'd1);
         check("stall_dat", dn_if.dat,      last_in);
      end
      ack_mode = 1;
      push_samples(TAKES_FRM - 60, 1'b0, cyc_used);
      wait_done(2);
      check("t2_beats", 32'(beats), 32'(BEATS_FRM));

      // Guard bins are acknowledged while ACK_I is low and nothing is pending.
      beats    = 0;
      ack_mode = 0;
      push_samples(28, 1'b0, cyc_used);
      check("guard_cycles", 32'(cyc_used),  32'd28);
      check("guard_no_stb", 32'(dn_if.stb), 32'd0);
      push_samples(1, 1'b0, cyc_used);
      tick();
      @(negedge clk);
      check("k28_stb", 32'(dn_if.stb), 32'd1);
      check("k28_dat", dn_if.dat,      k28_val);
      check("k28_ack", 32'(up_if.ack), 32'd0);
      ack_mode = 1;
      push_samples(TAKES_FRM - 29, 1'b0, cyc_used);
      wait_done(3);
      check("t3_beats", 32'(beats), 32'(BEATS_FRM));

      // Abort at k = 100 of symbol 1 with the last beat still pending.
      beats = 0;
      push_samples(256 + 100, 1'b0, cyc_used);
      ack_mode = 0;
      tick();
      up_if.cyc = 1'b0;
      up_if.stb = 1'b0;
      @(negedge clk);
      check("abort_err",      32'(err),       32'd1);
      check("abort_stb_pend", 32'(dn_if.stb), 32'd1);
      tick();
      @(negedge clk);
      check("abort_sym_idx",  32'(sym_idx),   32'd0);
      check("abort_err_once", 32'(err),       32'd0);
      check("abort_cyc_hold", 32'(dn_if.cyc), 32'd1);
      ack_mode = 1;
      for (int i = 0; i < 8 && dn_if.cyc; i++) begin
         tick();
         @(negedge clk);
      end
      check("abort_cyc_drop", 32'(dn_if.cyc), 32'd0);
      tick();
      check("abort_err_cnt",  32'(n_err), 32'd1);
      check("abort_beats",    32'(beats), 32'd261);
      check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
      tb_k   = 0;
      tb_sym = 0;
      beats  = 0;
      push_samples(TAKES_FRM, 1'b0, cyc_used);
      wait_done(4);
      check("t4_beats", 32'(beats), 32'(BEATS_FRM));
      check("t4_first", first_dat,  k28_val);

      // Reset in the middle of a frame.
      beats = 0;
      push_samples(150, 1'b0, cyc_used);
      tick();
      rst       = 1'b1;
      up_if.stb = 1'b0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_stb",  32'(dn_if.stb), 32'd0);
      check("mrst_cyc",  32'(dn_if.cyc), 32'd0);
      check("mrst_we",   32'(dn_if.we),  32'd0);
      check("mrst_dat",  dn_if.dat,      32'd0);
      check("mrst_sym",  32'(sym_idx),   32'd0);
      check("mrst_done", 32'(frm_done),  32'd0);
      check("mrst_err",  32'(err),       32'd0);
      check("mrst_ack",  32'(up_if.ack), 32'd0);
      check("mrst_sb_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tb_k   = 0;
      tb_sym = 0;
      tick();
      beats = 0;
      push_samples(TAKES_FRM, 1'b0, cyc_used);
      wait_done(5);
      check("t5_beats", 32'(beats), 32'(BEATS_FRM));
      check("t5_first", first_dat,  k28_val);

      // Random ACK_I and upstream gaps over three back-to-back frames.
      ack_mode = 2;
      beats    = 0;
      for (int f = 0; f < 3; f++) push_samples(TAKES_FRM, 1'b1, cyc_used);
      wait_done(8);
      check("rnd_beats",     32'(beats), 32'(3 * BEATS_FRM));
      check("rnd_sb_empty",  32'(exp_q.size()), 32'd0);
      check("rnd_done_mdl",  32'(n_done), 32'(exp_done));
      check("rnd_err_cnt",   32'(n_err),  32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
